// File: rtl/game_pkg.sv
// Shared types and status encodings for the number-guessing game level controller.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        ADVANCE = 2'd1,
        WIN     = 2'd2,
        LOSE    = 2'd3
    } game_state_t;

    localparam logic [1:0] ST_PLAY = 2'b11;
    localparam logic [1:0] ST_ADV  = 2'b10;
    localparam logic [1:0] ST_WIN  = 2'b01;
    localparam logic [1:0] ST_LOSE = 2'b00;

    function automatic logic is_final(input game_state_t s);
        return (s == WIN) || (s == LOSE);
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector; previous value resets high so a level held through reset is no edge.
module rise_edge (
    input  logic clk,
    input  logic restart,
    input  logic din,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din;
        end
    end

    assign pulse = din & ~prev_q;

endmodule

// File: rtl/game_level_ctrl.sv
// Level controller: walks the player through NUM_LEVELS levels, detects win/loss/timeout,
// and derives per-level digit count and miss budget from the registered level.
module game_level_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_LEVELS      = 3,
    parameter int unsigned LVL_W           = 2,
    parameter int unsigned TIMER_W         = 7,
    parameter int unsigned GUESS_W         = 3,
    parameter int unsigned ROUND_W         = 3,
    parameter int unsigned ROUNDS_TO_CLEAR = 5,
    parameter int unsigned BASE_MISSES     = 3,
    parameter int unsigned DIGIT_BASE      = 1
) (
    input  logic               clk,
    input  logic               restart,
    input  logic               confirm_btn,
    input  logic [TIMER_W-1:0] timer,
    input  logic               timer_run,
    input  logic [GUESS_W-1:0] incorrect_guesses,
    input  logic [ROUND_W-1:0] round,
    input  logic               new_game,
    output logic [LVL_W-1:0]   level,
    output logic [LVL_W:0]     max_digit,
    output logic [GUESS_W-1:0] max_incorrect,
    output logic [1:0]         status,
    output logic               level_up,
    output logic               game_done
);

    if (NUM_LEVELS < 1 || (2 ** LVL_W) < NUM_LEVELS) begin : g_bad_params
        $error("game_level_ctrl: LVL_W too small for NUM_LEVELS");
    end

    localparam logic [LVL_W-1:0]   LastLevel = LVL_W'(NUM_LEVELS - 1);
    localparam logic [ROUND_W-1:0] ClearRnd  = ROUND_W'(ROUNDS_TO_CLEAR);

    game_state_t      state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             done_q, done_d;
    logic             conf_edge;

    rise_edge u_conf_edge (
        .clk     (clk),
        .restart (restart),
        .din     (confirm_btn),
        .pulse   (conf_edge)
    );

    // One extra bit on each sum exposes overflow to the assertions below.
    logic [GUESS_W:0] budget_ext;
    logic [LVL_W+1:0] digit_ext;
    logic [GUESS_W-1:0] budget;

    assign budget_ext = (GUESS_W+1)'(BASE_MISSES) + (GUESS_W+1)'(level_q);
    assign digit_ext  = (LVL_W+2)'(DIGIT_BASE) + (LVL_W+2)'(level_q);
    assign budget     = budget_ext[GUESS_W-1:0];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            PLAY: begin
                // Timeout and miss-out both outrank a level clear.
                if (timer_run && (timer == '0)) begin
                    state_d = LOSE;
                end else if (conf_edge) begin
                    if (incorrect_guesses >= budget) begin
                        state_d = LOSE;
                    end else if (round >= ClearRnd) begin
                        state_d = (level_q == LastLevel) ? WIN : ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                state_d = PLAY;
                level_d = level_q + LVL_W'(1);
            end
            WIN, LOSE: begin
                if (new_game) begin
                    state_d = PLAY;
                    level_d = '0;
                end
            end
            default: begin
                state_d = PLAY;
                level_d = '0;
            end
        endcase
    end

    assign done_d = is_final(state_d) && !is_final(state_q);

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q <= PLAY;
            level_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        level         = level_q;
        max_digit     = digit_ext[LVL_W:0];
        max_incorrect = budget;
        status        = ST_PLAY;
        level_up      = 1'b0;
        game_done     = done_q;
        unique case (state_q)
            PLAY: status = ST_PLAY;
            ADVANCE: begin
                status   = ST_ADV;
                level_up = 1'b1;
            end
            WIN: begin
                status        = ST_WIN;
                max_digit     = '0;
                max_incorrect = '0;
            end
            LOSE: begin
                status        = ST_LOSE;
                max_digit     = '0;
                max_incorrect = '0;
            end
            default: status = ST_PLAY;
        endcase
    end

    a_budget_fits: assert property (@(posedge clk) disable iff (!restart)
        budget_ext[GUESS_W] == 1'b0);
    a_digits_fit: assert property (@(posedge clk) disable iff (!restart)
        digit_ext[LVL_W+1] == 1'b0);

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed bench for game_level_ctrl with hand-computed expectations.
module tb_game_level_ctrl;

    logic       clk = 1'b0;
    logic       restart;
    logic       confirm_btn;
    logic [6:0] timer;
    logic       timer_run;
    logic [2:0] incorrect_guesses;
    logic [2:0] round;
    logic       new_game;
    logic [1:0] level;
    logic [2:0] max_digit;
    logic [2:0] max_incorrect;
    logic [1:0] status;
    logic       level_up;
    logic       game_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_level_ctrl dut (
        .clk               (clk),
        .restart           (restart),
        .confirm_btn       (confirm_btn),
        .timer             (timer),
        .timer_run         (timer_run),
        .incorrect_guesses (incorrect_guesses),
        .round             (round),
        .new_game          (new_game),
        .level             (level),
        .max_digit         (max_digit),
        .max_incorrect     (max_incorrect),
        .status            (status),
        .level_up          (level_up),
        .game_done         (game_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop confirm for a cycle, then raise it: the raise is seen on the following edge.
    task automatic press();
        confirm_btn = 1'b0;
        step();
        confirm_btn = 1'b1;
        step();
    endtask

    initial begin
        int ups;
        restart           = 1'b0;
        confirm_btn       = 1'b1;
        timer             = 7'd100;
        timer_run         = 1'b0;
        incorrect_guesses = 3'd2;
        round             = 3'd5;
        new_game          = 1'b0;
        #12;
        chk("rst_status", status, 2'b11);
        chk("rst_level", level, 0);
        chk("rst_digit", max_digit, 1);
        chk("rst_budget", max_incorrect, 3);
        chk("rst_lvlup", level_up, 0);
        chk("rst_done", game_done, 0);

        // Confirm held through reset is not an edge.
        step();
        restart = 1'b1;
        step();
        step();
        chk("held_status", status, 2'b11);
        chk("held_level", level, 0);

        press();
        chk("adv_lvlup", level_up, 1);
        chk("adv_status", status, 2'b10);
        step();
        chk("l1_level", level, 1);
        chk("l1_digit", max_digit, 2);
        chk("l1_budget", max_incorrect, 4);
        chk("l1_lvlup", level_up, 0);

        ups = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (level_up) ups++;
        end
        chk("hold_no_extra_up", ups, 0);
        chk("hold_level", level, 1);

        // Loss beats clear at level 1 (budget 4).
        incorrect_guesses = 3'd4;
        press();
        chk("lose_status", status, 2'b00);
        chk("lose_done", game_done, 1);
        chk("lose_digit", max_digit, 0);
        chk("lose_budget", max_incorrect, 0);
        step();
        chk("lose_done_pulse", game_done, 0);
        press();
        chk("lose_sticky", status, 2'b00);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_status", status, 2'b11);
        chk("ng_level", level, 0);

        // Timeout only counts while the timer runs.
        incorrect_guesses = 3'd0;
        timer = 7'd0;
        step();
        step();
        chk("tmo_stopped", status, 2'b11);
        timer_run = 1'b1;
        step();
        chk("tmo_status", status, 2'b00);
        chk("tmo_done", game_done, 1);
        timer_run = 1'b0;
        timer = 7'd100;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("tmo_ng", status, 2'b11);

        // Clear all three levels.
        round = 3'd5;
        press();
        step();
        press();
        step();
        chk("l2_level", level, 2);
        chk("l2_digit", max_digit, 3);
        chk("l2_budget", max_incorrect, 5);
        press();
        chk("win_status", status, 2'b01);
        chk("win_done", game_done, 1);
        chk("win_digit", max_digit, 0);
        press();
        chk("win_sticky", status, 2'b01);
        chk("win_done_once", game_done, 0);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("win_ng_status", status, 2'b11);
        chk("win_ng_level", level, 0);

        // new_game has no effect while playing.
        press();
        step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_in_play", level, 1);

        // Asynchronous reset in the middle of ADVANCE.
        press();
        chk("pre_rst_adv", status, 2'b10);
        #2;
        restart = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_status", status, 2'b11);
        chk("mid_rst_lvlup", level_up, 0);
        step();
        restart = 1'b1;
        step();
        chk("post_rst_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
